// File: rtl/pipelined_variable_shifter.sv
// Pipelined logarithmic barrel shifter: LSR, ASR, LSL and ROR by a run-time
// amount. Stage k shifts by 2^k when amount bit k is set, and each stage
// carries the amount, op and original sign bit along with the data.
module pipelined_variable_shifter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  output logic [N-1:0]         out_data
);

  localparam int W = $clog2(N);

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;

  // One shift step by a fixed distance s. ASR fills with the carried sign
  // bit rather than the MSB of the partially shifted data.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d,
                                            input logic [1:0]   op,
                                            input logic         sign,
                                            input int           s);
    logic [N-1:0] fill;
    fill = ~({N{1'b1}} >> s);
    case (op)
      OP_LSR:  return d >> s;
      OP_ASR:  return (d >> s) | (sign ? fill : '0);
      OP_LSL:  return d << s;
      default: return (d >> s) | (d << (N - s));
    endcase
  endfunction

  // Pipeline registers, one entry per stage.
  logic         valid_q [W];
  logic [N-1:0] data_q  [W];
  logic [W-1:0] amt_q   [W];
  logic [1:0]   op_q    [W];
  logic         sign_q  [W];

  // What each stage sees at its input, and the shifted data it would load.
  logic         src_valid [W];
  logic [N-1:0] src_data  [W];
  logic [W-1:0] src_amt   [W];
  logic [1:0]   src_op    [W];
  logic         src_sign  [W];
  logic [N-1:0] shifted   [W];

  genvar k;
  generate
    for (k = 0; k < W; k++) begin : g_stage
      if (k == 0) begin : g_src
        assign src_valid[k] = in_valid;
        assign src_data[k]  = in_data;
        assign src_amt[k]   = in_amt;
        assign src_op[k]    = in_op;
        assign src_sign[k]  = in_data[N-1];
      end else begin : g_src
        assign src_valid[k] = valid_q[k-1];
        assign src_data[k]  = data_q[k-1];
        assign src_amt[k]   = amt_q[k-1];
        assign src_op[k]    = op_q[k-1];
        assign src_sign[k]  = sign_q[k-1];
      end
      assign shifted[k] = src_amt[k][k] ? shift_by(src_data[k], src_op[k], src_sign[k], 1 << k)
                                        : src_data[k];
    end
  endgenerate

  // Valid bits advance every cycle; a stage's payload loads only when its
  // upstream is valid, so out_data holds steady through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        amt_q[i]   <= '0;
        op_q[i]    <= '0;
        sign_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        valid_q[i] <= src_valid[i];
        if (src_valid[i]) begin
          data_q[i] <= shifted[i];
          amt_q[i]  <= src_amt[i];
          op_q[i]   <= src_op[i];
          sign_q[i] <= src_sign[i];
        end
      end
    end
  end

  assign out_valid = valid_q[W-1];
  assign out_data  = data_q[W-1];

endmodule

// File: tb/tb_pipelined_variable_shifter.sv
// Self-checking bench for pipelined_variable_shifter (N=8, latency 3 cycles).
module tb_pipelined_variable_shifter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic [W-1:0] in_amt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic [N-1:0] out_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  pipelined_variable_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Behavioural reference: plain shift operators and a doubled-word rotate.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int a,
                                             input logic [1:0] op);
    logic [2*N-1:0] dd;
    case (op)
      2'b00:   return d >> a;
      2'b01:   return N'($signed(d) >>> a);
      2'b10:   return d << a;
      default: begin
        dd = {d, d} >> a;
        return dd[N-1:0];
      end
    endcase
  endfunction

  // Present one input cycle, then move to 1 unit after the sampling edge.
  task automatic drive(input logic v, input logic [N-1:0] d, input logic [W-1:0] a,
                       input logic [1:0] op);
    in_valid = v;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, N'($urandom), W'($urandom), 2'($urandom));
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_amt   = 3'd1;
    in_op    = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
    end
    n_compared++;
    if (out_data !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h want 00", out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_ops();
    logic [N-1:0] exp_ops [4];
    exp_ops = '{8'h12, 8'hF2, 8'hB0, 8'hD2};
    for (int op = 0; op < 4; op++) begin
      for (int j = 0; j < 5; j++) begin
        if (j == 0) drive(1'b1, 8'b1001_0110, 3'd3, 2'(op));
        else        drive_idle();
        n_compared++;
        if (out_valid !== (j == 2)) begin
          n_mismatched++;
          $display("[TB] FAIL ops_valid op=%0d step=%0d: got %b want %b", op, j, out_valid, (j == 2));
        end
        if (j == 2) begin
          n_compared++;
          if (out_data !== exp_ops[op]) begin
            n_mismatched++;
            $display("[TB] FAIL ops_data op=%0d: got %h want %h", op, out_data, exp_ops[op]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_ops [4];
    exp_ops = '{8'h12, 8'hF2, 8'hB0, 8'hD2};
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(1'b1, 8'b1001_0110, 3'd3, 2'(j));
      else       drive_idle();
      n_compared++;
      if (out_valid !== (j >= 2 && j <= 5)) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_valid step=%0d: got %b", j, out_valid);
      end
      if (j >= 2 && j <= 5) begin
        n_compared++;
        if (out_data !== exp_ops[j-2]) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_data step=%0d: got %h want %h", j, out_data, exp_ops[j-2]);
        end
      end
    end
  endtask

  task automatic test_corners();
    logic [N-1:0] exp_c [8];
    exp_c = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h01, 8'hFF, 8'h80, 8'h03};
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive(1'b1, 8'h81, (j < 4) ? 3'd0 : 3'd7, 2'(j % 4));
      else       drive_idle();
      if (j >= 2) begin
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== exp_c[j-2]) begin
          n_mismatched++;
          $display("[TB] FAIL corner_%0d: got v=%b d=%h want v=1 d=%h", j - 2, out_valid, out_data, exp_c[j-2]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int j = 0; j < 3; j++) drive(1'b1, N'($urandom), W'($urandom), 2'($urandom));
    n_compared++;
    if (out_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_pre_valid: got %b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_clear: got v=%b d=%h want v=0 d=00", out_valid, out_data);
    end
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      drive_idle();
      n_compared++;
      if (out_valid !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL midreset_stale step=%0d: got %b want 0", j, out_valid);
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 0) drive(1'b1, 8'b1001_0110, 3'd3, 2'b00);
      else        drive_idle();
      n_compared++;
      if (out_valid !== (j == 2) || (j == 2 && out_data !== 8'h12)) begin
        n_mismatched++;
        $display("[TB] FAIL midreset_new step=%0d: got v=%b d=%h", j, out_valid, out_data);
      end
    end
  endtask

  task automatic test_gap();
    logic [N-1:0] da, dc;
    logic [W-1:0] aa, ac;
    logic [1:0]   oa, oc;
    da = N'($urandom); aa = W'($urandom); oa = 2'($urandom);
    dc = N'($urandom); ac = W'($urandom); oc = 2'($urandom);
    drive(1'b1, da, aa, oa);
    drive_idle();
    drive(1'b1, dc, ac, oc);
    n_compared++;
    if (out_valid !== 1'b1 || out_data !== ref_shift(da, aa, oa)) begin
      n_mismatched++;
      $display("[TB] FAIL gap_first: got v=%b d=%h want v=1 d=%h", out_valid, out_data, ref_shift(da, aa, oa));
    end
    drive_idle();
    n_compared++;
    if (out_valid !== 1'b0 || out_data !== ref_shift(da, aa, oa)) begin
      n_mismatched++;
      $display("[TB] FAIL gap_bubble: got v=%b d=%h want v=0 d=%h", out_valid, out_data, ref_shift(da, aa, oa));
    end
    drive_idle();
    n_compared++;
    if (out_valid !== 1'b1 || out_data !== ref_shift(dc, ac, oc)) begin
      n_mismatched++;
      $display("[TB] FAIL gap_third: got v=%b d=%h want v=1 d=%h", out_valid, out_data, ref_shift(dc, ac, oc));
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic         exp_v [$];
    logic [N-1:0] exp_d [$];
    logic         v, ev;
    logic [N-1:0] d, ed;
    logic [W-1:0] a;
    logic [1:0]   op;
    for (int j = 0; j < 1002; j++) begin
      v  = (j < 1000) ? ($urandom_range(3) != 0) : 1'b0;
      d  = N'($urandom);
      a  = W'($urandom);
      op = 2'($urandom);
      drive(v, d, a, op);
      exp_v.push_back(v);
      exp_d.push_back(ref_shift(d, a, op));
      if (exp_v.size() == 3) begin
        ev = exp_v.pop_front();
        ed = exp_d.pop_front();
        n_compared++;
        if (out_valid !== ev || (ev && out_data !== ed)) begin
          n_mismatched++;
          $display("[TB] FAIL random_%0d: got v=%b d=%h want v=%b d=%h", j - 2, out_valid, out_data, ev, ed);
        end
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_amt   = '0;
    in_op    = '0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_corners();
    test_reset_midflight();
    test_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
